// File: rtl/uart_rx_stream.sv
// UART receiver: oversampled 2-of-3 majority bit recovery, optional parity, 1/2 stop bits.
// Latency: valid_o rises 1 cycle after the last stop-bit vote; rx_i to start detect is 2-3 cycles.
// Backpressure: one-word output register; a frame completing while the word is held and not accepted is dropped with an overrun_o pulse.
module uart_rx_stream #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_WIDTH = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  parity_err_o,
    output logic                  frame_err_o,
    output logic                  overrun_o,
    output logic                  busy_o
);

    localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TC_W  = $clog2(OVERSAMPLE);
    localparam int BC_W  = $clog2(DATA_WIDTH + 1);
    localparam int MID   = OVERSAMPLE / 2;

    // Reject parameter sets the datapath cannot honour.
    if (DIV < 1) begin : g_bad_div
        $error("uart_rx_stream: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE");
    end
    if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
        $error("uart_rx_stream: DATA_WIDTH must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_rx_stream: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_rx_stream: STOP_BITS must be 1 or 2");
    end
    if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
        $error("uart_rx_stream: OVERSAMPLE must be even and >= 4");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            rx_sync_q;
    logic                  rx_prev_q;
    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic [TC_W-1:0]       tick_cnt_q, tick_cnt_d;
    logic                  samp0_q, samp0_d;
    logic                  samp1_q, samp1_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BC_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic                  par_q, par_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic                  perr_pend_q, perr_pend_d;
    logic                  ferr_pend_q, ferr_pend_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  overrun_q, overrun_d;

    logic rx_s;
    logic fall;
    logic tick;
    logic vote_vld;
    logic vote;
    logic complete;
    logic ferr_final;

    assign rx_s = rx_sync_q[1];
    assign fall = rx_prev_q & ~rx_s;
    assign tick = (div_cnt_q == DIV_W'(DIV - 1));

    // Two-flop synchroniser and edge register; idle-high so reset to 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync_q <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            rx_sync_q <= {rx_sync_q[0], rx_i};
            rx_prev_q <= rx_s;
        end
    end

    // Majority vote over the three ticks straddling the bit centre.
    always_comb begin
        samp0_d  = samp0_q;
        samp1_d  = samp1_q;
        vote_vld = 1'b0;
        vote     = (samp0_q & samp1_q) | (samp0_q & rx_s) | (samp1_q & rx_s);
        if (tick && tick_cnt_q == TC_W'(MID - 1)) samp0_d = rx_s;
        if (tick && tick_cnt_q == TC_W'(MID))     samp1_d = rx_s;
        if (tick && tick_cnt_q == TC_W'(MID + 1) && state_q != S_IDLE) vote_vld = 1'b1;
    end

    // Receive FSM: next state, bit assembly, counters and pending error flags.
    always_comb begin
        state_d     = state_q;
        div_cnt_d   = tick ? '0 : div_cnt_q + 1'b1;
        tick_cnt_d  = tick_cnt_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        par_d       = par_q;
        stop_cnt_d  = stop_cnt_q;
        perr_pend_d = perr_pend_q;
        ferr_pend_d = ferr_pend_q;
        complete    = 1'b0;
        ferr_final  = ferr_pend_q | ~vote;
        if (tick) begin
            tick_cnt_d = (tick_cnt_q == TC_W'(OVERSAMPLE - 1)) ? '0 : tick_cnt_q + 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    state_d     = S_START;
                    div_cnt_d   = '0;
                    tick_cnt_d  = '0;
                    bit_cnt_d   = '0;
                    par_d       = 1'b0;
                    stop_cnt_d  = 1'b0;
                    perr_pend_d = 1'b0;
                    ferr_pend_d = 1'b0;
                end
            end
            S_START: begin
                // A high vote means the edge was a glitch: drop silently.
                if (vote_vld) state_d = vote ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (vote_vld) begin
                    shift_d   = {vote, shift_q[DATA_WIDTH-1:1]};
                    par_d     = par_q ^ vote;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BC_W'(DATA_WIDTH - 1)) begin
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (vote_vld) begin
                    perr_pend_d = (PARITY == 1) ? ~(par_q ^ vote) : (par_q ^ vote);
                    state_d     = S_STOP;
                end
            end
            S_STOP: begin
                if (vote_vld) begin
                    ferr_pend_d = ferr_final;
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        // Complete at the vote so a back-to-back start edge is not missed.
                        complete = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output word register: load on completion if free or being drained, else flag overrun.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        overrun_d = 1'b0;
        if (complete && (!valid_q || ready_i)) begin
            data_d  = shift_q;
            perr_d  = perr_pend_q;
            ferr_d  = ferr_final;
            valid_d = 1'b1;
        end else if (complete) begin
            overrun_d = 1'b1;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            div_cnt_q   <= '0;
            tick_cnt_q  <= '0;
            samp0_q     <= 1'b1;
            samp1_q     <= 1'b1;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            par_q       <= 1'b0;
            stop_cnt_q  <= 1'b0;
            perr_pend_q <= 1'b0;
            ferr_pend_q <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            tick_cnt_q  <= tick_cnt_d;
            samp0_q     <= samp0_d;
            samp1_q     <= samp1_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            par_q       <= par_d;
            stop_cnt_q  <= stop_cnt_d;
            perr_pend_q <= perr_pend_d;
            ferr_pend_q <= ferr_pend_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            overrun_q   <= overrun_d;
        end
    end

    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign parity_err_o = perr_q;
    assign frame_err_o  = ferr_q;
    assign overrun_o    = overrun_q;
    assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_stream.sv
// Directed bench: three receivers (8N1, 8E1, 8N2) at DIV = 1, T = 16 cycles.
// Inputs change 1 time unit after the rising edge; outputs are observed on the falling edge.
// A monitor logs handshakes, valid cycles and overrun pulses per receiver.
module tb_uart_rx_stream;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  [3];
    logic       rdy [3];
    logic [7:0] dat [3];
    logic       vld [3];
    logic       pe  [3];
    logic       fe  [3];
    logic       ovr [3];
    logic       bsy [3];

    int hs_cnt   [3];
    int vcyc     [3];
    int ovr_cnt  [3];
    int last_dat [3];
    int last_pe  [3];
    int last_fe  [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_rx_stream #(.CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .DATA_WIDTH(8),
                     .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16)) u_8n1 (
        .clk(clk), .rst(rst), .rx_i(rx[0]), .data_o(dat[0]), .valid_o(vld[0]),
        .ready_i(rdy[0]), .parity_err_o(pe[0]), .frame_err_o(fe[0]),
        .overrun_o(ovr[0]), .busy_o(bsy[0]));

    uart_rx_stream #(.CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .DATA_WIDTH(8),
                     .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(16)) u_8e1 (
        .clk(clk), .rst(rst), .rx_i(rx[1]), .data_o(dat[1]), .valid_o(vld[1]),
        .ready_i(rdy[1]), .parity_err_o(pe[1]), .frame_err_o(fe[1]),
        .overrun_o(ovr[1]), .busy_o(bsy[1]));

    uart_rx_stream #(.CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .DATA_WIDTH(8),
                     .PARITY(0), .STOP_BITS(2), .OVERSAMPLE(16)) u_8n2 (
        .clk(clk), .rst(rst), .rx_i(rx[2]), .data_o(dat[2]), .valid_o(vld[2]),
        .ready_i(rdy[2]), .parity_err_o(pe[2]), .frame_err_o(fe[2]),
        .overrun_o(ovr[2]), .busy_o(bsy[2]));

    // Output monitor.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (vld[i] && rdy[i]) begin
                hs_cnt[i]   = hs_cnt[i] + 1;
                last_dat[i] = int'(dat[i]);
                last_pe[i]  = int'(pe[i]);
                last_fe[i]  = int'(fe[i]);
            end
            if (vld[i]) vcyc[i] = vcyc[i] + 1;
            if (ovr[i]) ovr_cnt[i] = ovr_cnt[i] + 1;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // Drive bits[0] first, each for one bit period; optionally invert one cycle at a bit centre.
    task automatic send(input int idx, input logic [15:0] bits, input int n, input int flip_bit);
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < T; c++) begin
                rx[idx] = (b == flip_bit && c == 7) ? ~bits[b] : bits[b];
                step();
            end
        end
        rx[idx] = 1'b1;
    endtask

    int hs0, vc0, ov0;

    initial begin
        for (int i = 0; i < 3; i++) begin
            rx[i] = 1'b1; rdy[i] = 1'b1;
            hs_cnt[i] = 0; vcyc[i] = 0; ovr_cnt[i] = 0;
            last_dat[i] = 0; last_pe[i] = 0; last_fe[i] = 0;
        end
        idle(3);
        chk("rst_data",  int'(dat[0]), 0);
        chk("rst_valid", int'(vld[0]), 0);
        chk("rst_perr",  int'(pe[0]),  0);
        chk("rst_ferr",  int'(fe[0]),  0);
        chk("rst_ovr",   int'(ovr[0]), 0);
        chk("rst_busy",  int'(bsy[0]), 0);
        rst = 1'b0;
        idle(5);

        // 8N1 0xA5.
        hs0 = hs_cnt[0]; vc0 = vcyc[0];
        send(0, 16'({1'b1, 8'hA5, 1'b0}), 10, -1);
        idle(4);
        chk("a5_hs",    hs_cnt[0] - hs0, 1);
        chk("a5_vcyc",  vcyc[0] - vc0, 1);
        chk("a5_data",  last_dat[0], 'hA5);
        chk("a5_perr",  last_pe[0], 0);
        chk("a5_ferr",  last_fe[0], 0);
        chk("a5_busy",  int'(bsy[0]), 0);

        // 8E1 0x3C (four ones): parity bit 1 is wrong, 0 is right.
        hs0 = hs_cnt[1];
        send(1, 16'({1'b1, 1'b1, 8'h3C, 1'b0}), 11, -1);
        idle(4);
        chk("par1_hs",   hs_cnt[1] - hs0, 1);
        chk("par1_data", last_dat[1], 'h3C);
        chk("par1_perr", last_pe[1], 1);
        send(1, 16'({1'b1, 1'b0, 8'h3C, 1'b0}), 11, -1);
        idle(4);
        chk("par0_hs",   hs_cnt[1] - hs0, 2);
        chk("par0_perr", last_pe[1], 0);
        chk("par0_ferr", last_fe[1], 0);

        // 8N2 with the second stop bit low.
        hs0 = hs_cnt[2];
        send(2, 16'({1'b0, 1'b1, 8'h96, 1'b0}), 12, -1);
        idle(32);
        chk("stop2_hs",   hs_cnt[2] - hs0, 1);
        chk("stop2_data", last_dat[2], 'h96);
        chk("stop2_ferr", last_fe[2], 1);
        // Break for three frame times: one zero word with frame error, then silence.
        hs0 = hs_cnt[2];
        rx[2] = 1'b0;
        idle(3 * 12 * T);
        chk("brk_hs",   hs_cnt[2] - hs0, 1);
        chk("brk_data", last_dat[2], 0);
        chk("brk_ferr", last_fe[2], 1);
        rx[2] = 1'b1;
        idle(40);
        chk("brk_hs_after", hs_cnt[2] - hs0, 1);
        chk("brk_busy", int'(bsy[2]), 0);

        // Overrun: hold ready low across two frames.
        rdy[0] = 1'b0;
        hs0 = hs_cnt[0]; ov0 = ovr_cnt[0];
        send(0, 16'({1'b1, 8'h11, 1'b0}), 10, -1);
        send(0, 16'({1'b1, 8'h22, 1'b0}), 10, -1);
        idle(4);
        chk("ovr_data",  int'(dat[0]), 'h11);
        chk("ovr_valid", int'(vld[0]), 1);
        chk("ovr_pulse", ovr_cnt[0] - ov0, 1);
        chk("ovr_hs0",   hs_cnt[0] - hs0, 0);
        rdy[0] = 1'b1;
        idle(3);
        chk("ovr_hs1",    hs_cnt[0] - hs0, 1);
        chk("ovr_hsdata", last_dat[0], 'h11);
        chk("ovr_vld0",   int'(vld[0]), 0);

        // 5-cycle glitch is a false start.
        hs0 = hs_cnt[0];
        rx[0] = 1'b0;
        idle(5);
        rx[0] = 1'b1;
        idle(40);
        chk("glitch_hs",   hs_cnt[0] - hs0, 0);
        chk("glitch_busy", int'(bsy[0]), 0);
        // One-cycle flip at the centre of data bit 3 (frame bit 4) is outvoted.
        send(0, 16'({1'b1, 8'hC3, 1'b0}), 10, 4);
        idle(4);
        chk("flip_hs",   hs_cnt[0] - hs0, 1);
        chk("flip_data", last_dat[0], 'hC3);

        // Reset in the middle of the data bits.
        send(0, 16'({1'b1, 8'h5A, 1'b0}), 4, -1);
        chk("mid_busy", int'(bsy[0]), 1);
        rx[0] = 1'b1;
        rst = 1'b1;
        #1;
        chk("mrst_data",  int'(dat[0]), 0);
        chk("mrst_busy",  int'(bsy[0]), 0);
        chk("mrst_valid", int'(vld[0]), 0);
        idle(3);
        rst = 1'b0;
        idle(20);
        hs0 = hs_cnt[0];
        send(0, 16'({1'b1, 8'h5A, 1'b0}), 10, -1);
        idle(4);
        chk("post_hs",   hs_cnt[0] - hs0, 1);
        chk("post_data", last_dat[0], 'h5A);
        chk("post_ferr", last_fe[0], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
